alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Captures decoded operands, the immediate and the 4-bit ALU control code from decode under a valid/ready handshake.
- Resolves data hazards by forwarding from EX/MEM and MEM/WB, and inserts a bubble on load-use.
- Drives the ALU's inp1, inp2 and alu_control inputs.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
Clock, reset and control:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill held and incoming instruction (branch mispredict).

Decode-side handshake and operands:
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_rs1_addr  in  RA_W  source register 1 address.
- in_rs2_addr  in  RA_W  source register 2 address.
- in_rs1_data  in  XLEN  register file read data 1.
- in_rs2_data  in  XLEN  register file read data 2.
- in_imm  in  XLEN  sign-extended immediate.
- in_use_imm  in  1  1 selects in_imm for the second operand.
- in_alu_control  in  4  ALU operation code.
- in_rd_addr  in  RA_W  destination register.
- in_reg_write  in  1  instruction writes rd.

Forwarding sources:
- ex_fwd_we  in  1  EX/MEM stage writes a register.
- ex_fwd_rd  in  RA_W  EX/MEM destination.
- ex_fwd_data  in  XLEN  EX/MEM ALU result.
- ex_fwd_is_load  in  1  EX/MEM instruction is a load; data not yet available.
- wb_fwd_we  in  1  MEM/WB writes the register file this cycle.
- wb_fwd_rd  in  RA_W  MEM/WB destination.
- wb_fwd_data  in  XLEN  MEM/WB write data.

ALU-side outputs:
- out_valid  out  1  operands valid for the ALU.
- out_ready  in  1  downstream accepts.
- inp1  out  XLEN  ALU operand 1.
- inp2  out  XLEN  ALU operand 2.
- alu_control  out  4  ALU operation code.
- out_rd_addr  out  RA_W  destination, passed through.
- out_reg_write  out  1  write enable, passed through.

Behaviour:
Storage:
- One-entry register: held_valid, rs1/rs2 addr and data, imm, use_imm, alu_control, rd, reg_write.
- Reset (synchronous, rst=1 at an edge): every stored field and held_valid go to 0.
- After reset: out_valid=0, inp1=0, inp2=0, alu_control=4'b0000, out_rd_addr=0, out_reg_write=0.

Handshake:
- out_fire = out_valid & out_ready.
- in_ready = ~held_valid | out_fire (combinational).
- Capture when in_valid & in_ready & ~flush; an accepted instruction is visible on the outputs one cycle later.
- Back-to-back throughput is 1 per cycle.
- held_valid clears on out_fire without capture.

Capture bypass:
- When wb_fwd_we, wb_fwd_rd == in_rsN_addr and in_rsN_addr != 0, store wb_fwd_data instead of in_rsN_data.
- This covers a same-cycle register file write/read.

Hold update:
- While held_valid and not firing, the same MEM/WB match rule overwrites stored rsN data.
- Operands therefore stay correct across stalls of any length.

Output forwarding (combinational, per operand; priority high to low):
1. Address 0 always uses the stored data, which is 0 for x0.
2. ex_fwd_we & ex_fwd_rd match & ~ex_fwd_is_load → ex_fwd_data.
3. wb_fwd_we & wb_fwd_rd match → wb_fwd_data.
4. Otherwise the stored data.

Operand selection:
- inp2 = use_imm ? imm : forwarded rs2.
- A register used only as rs2 under use_imm never triggers a hazard.

Load-use:
- load_use = held_valid & ex_fwd_we & ex_fwd_is_load & ex_fwd_rd != 0 & (ex_fwd_rd == rs1_addr | (~use_imm & ex_fwd_rd == rs2_addr)).
- out_valid = held_valid & ~load_use, so in_ready stays low and the entry holds.
- The next cycle the load sits in MEM/WB, and the hold update plus MEM/WB forwarding resolve it.

Flush:
- held_valid <= 0 next edge regardless of out_ready or in_valid.
- An incoming instruction in the same cycle is dropped; in_ready is still driven per the rule above.
- Other stored fields retain their values (don't-care).

Reset priority:
- rst has priority over flush and capture.
- Reset mid-stall discards the held entry.

Arithmetic: no arithmetic in this stage; all data paths are pure muxes at XLEN.

Decomposition:
- Shared package riscv_pkg:
  - XLEN and RA_W localparams.
  - ALU op constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SLL=0011, ALU_SUB=0100, ALU_SRL=0101, ALU_MUL=0110, ALU_XOR=0111, ALU_SLT=1000.
  - fwd_sel_t enum {FWD_REG, FWD_EX, FWD_WB}.
- Sub-module operand_fwd_mux:
  - Inputs: address, stored data, both forwarding sources.
  - Outputs: data and the load-hazard bit.
  - Instantiated twice, for rs1 and rs2.

Test Plan:
1. Reset, then ADD with rs1=x1 (5), rs2=x2 (7), no forwarding, out_ready=1 → next cycle out_valid=1, inp1=5, inp2=7, alu_control=0010; in_ready stays 1 for back-to-back.
2. Held instr rs1=x3 (stored 1), ex_fwd_we=1, ex_fwd_rd=3, ex_fwd_data=0xAA, and simultaneously wb_fwd_rd=3, wb_fwd_data=0xBB → inp1=0xAA (EX priority); with ex_fwd_we=0 → inp1=0xBB; with rs1=x0 and all sources targeting x0 → inp1=0.
3. Load-use: held rs2=x4, use_imm=0, ex_fwd_is_load=1, ex_fwd_rd=4 → out_valid=0, in_ready=0 for one cycle; next cycle wb_fwd_rd=4, wb_fwd_data=0x1234 → out_valid=1, inp2=0x1234. Repeat with use_imm=1, imm=0x10 → no bubble, inp2=0x10.
4. Stall: out_ready=0 for 5 cycles while MEM/WB writes x6=0x55 in cycle 2; held rs1=x6 → inp1=0x55 on every cycle after, including after the MEM/WB source departs; in_ready=0 throughout.
5. Flush with in_valid=1 and a held entry → next cycle out_valid=0 and no instruction captured; assert rst during a stall → out_valid=0, inp1=inp2=0, alu_control=0000.
6. Capture bypass: in_rs1_addr=7, in_rs1_data=0 (stale) while wb_fwd_we=1, wb_fwd_rd=7, wb_fwd_data=0x99 → after capture, with no forwarding active, inp1=0x99.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the integer pipeline: widths, ALU op codes
// and the forwarding source select used by the operand stage.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_EX,
    FWD_WB
  } fwd_sel_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand forwarding select: EX/MEM over MEM/WB over stored data, x0 never forwarded.
// Purely combinational; flags a load in EX/MEM that this operand depends on.
module operand_fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] addr,
  input  logic [XLEN-1:0] stored_data,
  input  logic            ex_we,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ex_is_load,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data,
  output logic            load_hazard
);
  import riscv_pkg::*;

  fwd_sel_t sel;

  always_comb begin
    sel = FWD_REG;
    if (addr != '0) begin
      if (ex_we && (ex_rd == addr) && !ex_is_load) begin
        sel = FWD_EX;
      end else if (wb_we && (wb_rd == addr)) begin
        sel = FWD_WB;
      end
    end
  end

  always_comb begin
    case (sel)
      FWD_EX:  data = ex_data;
      FWD_WB:  data = wb_data;
      default: data = stored_data;
    endcase
  end

  // A load result is not ready until MEM/WB, so it stalls rather than forwards.
  assign load_hazard = ex_we & ex_is_load & (addr != '0) & (ex_rd == addr);

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU: one-entry valid/ready slot with forwarding and load-use bubble.
// Accepted instruction appears one cycle later; in_ready drops while the slot is held and not firing.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [3:0]      in_alu_control,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic            in_reg_write,

  input  logic            ex_fwd_we,
  input  logic [RA_W-1:0] ex_fwd_rd,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic            ex_fwd_is_load,
  input  logic            wb_fwd_we,
  input  logic [RA_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] inp1,
  output logic [XLEN-1:0] inp2,
  output logic [3:0]      alu_control,
  output logic [RA_W-1:0] out_rd_addr,
  output logic            out_reg_write
);
  import riscv_pkg::*;

  logic            held_valid_q, held_valid_d;
  logic [RA_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [RA_W-1:0] rs2_addr_q, rs2_addr_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic            use_imm_q, use_imm_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic            reg_write_q, reg_write_d;

  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            haz_rs1, haz_rs2;
  logic            load_use, out_fire, capture;

  operand_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .addr        (rs1_addr_q),
    .stored_data (rs1_data_q),
    .ex_we       (ex_fwd_we),
    .ex_rd       (ex_fwd_rd),
    .ex_data     (ex_fwd_data),
    .ex_is_load  (ex_fwd_is_load),
    .wb_we       (wb_fwd_we),
    .wb_rd       (wb_fwd_rd),
    .wb_data     (wb_fwd_data),
    .data        (fwd_rs1),
    .load_hazard (haz_rs1)
  );

  operand_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .addr        (rs2_addr_q),
    .stored_data (rs2_data_q),
    .ex_we       (ex_fwd_we),
    .ex_rd       (ex_fwd_rd),
    .ex_data     (ex_fwd_data),
    .ex_is_load  (ex_fwd_is_load),
    .wb_we       (wb_fwd_we),
    .wb_rd       (wb_fwd_rd),
    .wb_data     (wb_fwd_data),
    .data        (fwd_rs2),
    .load_hazard (haz_rs2)
  );

  // rs2 is ignored under use_imm, so it cannot cause a bubble.
  assign load_use  = held_valid_q & (haz_rs1 | (~use_imm_q & haz_rs2));
  assign out_valid = held_valid_q & ~load_use;
  assign out_fire  = out_valid & out_ready;
  assign in_ready  = ~held_valid_q | out_fire;
  assign capture   = in_valid & in_ready & ~flush;

  assign inp1          = fwd_rs1;
  assign inp2          = use_imm_q ? imm_q : fwd_rs2;
  assign alu_control   = alu_ctrl_q;
  assign out_rd_addr   = rd_q;
  assign out_reg_write = reg_write_q;

  always_comb begin
    held_valid_d = held_valid_q;
    rs1_addr_d   = rs1_addr_q;
    rs2_addr_d   = rs2_addr_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    use_imm_d    = use_imm_q;
    alu_ctrl_d   = alu_ctrl_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;

    if (capture) begin
      held_valid_d = 1'b1;
      rs1_addr_d   = in_rs1_addr;
      rs2_addr_d   = in_rs2_addr;
      // Same-cycle register file write is not yet visible in the read data.
      rs1_data_d   = (wb_fwd_we && wb_fwd_rd == in_rs1_addr && in_rs1_addr != '0)
                     ? wb_fwd_data : in_rs1_data;
      rs2_data_d   = (wb_fwd_we && wb_fwd_rd == in_rs2_addr && in_rs2_addr != '0)
                     ? wb_fwd_data : in_rs2_data;
      imm_d        = in_imm;
      use_imm_d    = in_use_imm;
      alu_ctrl_d   = in_alu_control;
      rd_d         = in_rd_addr;
      reg_write_d  = in_reg_write;
    end else if (out_fire) begin
      held_valid_d = 1'b0;
    end else if (held_valid_q) begin
      // Absorb writebacks while stalled so the operands never go stale.
      if (wb_fwd_we && wb_fwd_rd == rs1_addr_q && rs1_addr_q != '0) begin
        rs1_data_d = wb_fwd_data;
      end
      if (wb_fwd_we && wb_fwd_rd == rs2_addr_q && rs2_addr_q != '0) begin
        rs2_data_d = wb_fwd_data;
      end
    end

    if (flush) begin
      held_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid_q <= 1'b0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      use_imm_q    <= 1'b0;
      alu_ctrl_q   <= 4'b0000;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      held_valid_q <= held_valid_d;
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      use_imm_q    <= use_imm_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for the ALU operand stage: handshake, forwarding priority,
// load-use bubble, stall hold update, flush, reset and capture bypass.
module tb_alu_operand_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm, in_reg_write;
  logic [3:0]  in_alu_control;
  logic        ex_fwd_we, ex_fwd_is_load, wb_fwd_we;
  logic [4:0]  ex_fwd_rd, wb_fwd_rd;
  logic [31:0] ex_fwd_data, wb_fwd_data;
  logic        out_valid, out_ready;
  logic [31:0] inp1, inp2;
  logic [3:0]  alu_control;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1_addr    (in_rs1_addr),
    .in_rs2_addr    (in_rs2_addr),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_imm         (in_imm),
    .in_use_imm     (in_use_imm),
    .in_alu_control (in_alu_control),
    .in_rd_addr     (in_rd_addr),
    .in_reg_write   (in_reg_write),
    .ex_fwd_we      (ex_fwd_we),
    .ex_fwd_rd      (ex_fwd_rd),
    .ex_fwd_data    (ex_fwd_data),
    .ex_fwd_is_load (ex_fwd_is_load),
    .wb_fwd_we      (wb_fwd_we),
    .wb_fwd_rd      (wb_fwd_rd),
    .wb_fwd_data    (wb_fwd_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .inp1           (inp1),
    .inp2           (inp2),
    .alu_control    (alu_control),
    .out_rd_addr    (out_rd_addr),
    .out_reg_write  (out_reg_write)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks follow one more unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_fwd();
    ex_fwd_we = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0; ex_fwd_is_load = 1'b0;
    wb_fwd_we = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
  endtask

  task automatic issue(input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2,
                       input logic [31:0] imm, input logic use_imm,
                       input logic [3:0] ctrl, input logic [4:0] rd);
    in_valid = 1'b1;
    in_rs1_addr = r1; in_rs1_data = d1;
    in_rs2_addr = r2; in_rs2_data = d2;
    in_imm = imm; in_use_imm = use_imm;
    in_alu_control = ctrl; in_rd_addr = rd; in_reg_write = 1'b1;
  endtask

  task automatic no_issue();
    in_valid = 1'b0;
    in_rs1_addr = '0; in_rs1_data = '0; in_rs2_addr = '0; in_rs2_data = '0;
    in_imm = '0; in_use_imm = 1'b0; in_alu_control = '0; in_rd_addr = '0; in_reg_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    no_issue();
    clr_fwd();
    tick(); tick();
    rst = 1'b0;
    settle();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_inp1", inp1, 32'd0);
    check("rst_inp2", inp2, 32'd0);
    check("rst_alu_control", {28'b0, alu_control}, 32'd0);
    check("rst_rd", {27'b0, out_rd_addr}, 32'd0);
    check("rst_reg_write", {31'b0, out_reg_write}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic ADD, then a back-to-back SUB.
    issue(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, ALU_ADD, 5'd3);
    tick();
    issue(5'd8, 32'h11, 5'd9, 32'h22, 32'd0, 1'b0, ALU_SUB, 5'd10);
    settle();
    check("add_out_valid", {31'b0, out_valid}, 32'd1);
    check("add_inp1", inp1, 32'd5);
    check("add_inp2", inp2, 32'd7);
    check("add_ctrl", {28'b0, alu_control}, 32'h2);
    check("add_rd", {27'b0, out_rd_addr}, 32'd3);
    check("add_reg_write", {31'b0, out_reg_write}, 32'd1);
    check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    no_issue();
    settle();
    check("sub_inp1", inp1, 32'h11);
    check("sub_inp2", inp2, 32'h22);
    check("sub_ctrl", {28'b0, alu_control}, 32'h4);
    tick();
    settle();
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);

    // Forwarding priority on a held entry.
    out_ready = 1'b0;
    issue(5'd3, 32'd1, 5'd5, 32'd2, 32'd0, 1'b0, ALU_AND, 5'd6);
    tick();
    no_issue();
    ex_fwd_we = 1'b1; ex_fwd_rd = 5'd3; ex_fwd_data = 32'hAA;
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'hBB;
    settle();
    check("fwd_ex_priority", inp1, 32'hAA);
    check("fwd_stall_in_ready", {31'b0, in_ready}, 32'd0);
    ex_fwd_we = 1'b0;
    settle();
    check("fwd_wb", inp1, 32'hBB);
    // Replace with an x0 instruction while every source targets x0.
    clr_fwd();
    out_ready = 1'b1;
    issue(5'd0, 32'd0, 5'd5, 32'd2, 32'd0, 1'b0, ALU_OR, 5'd6);
    tick();
    no_issue();
    out_ready = 1'b0;
    ex_fwd_we = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 32'hDEAD;
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'hBEEF;
    settle();
    check("fwd_x0_inp1", inp1, 32'd0);
    check("fwd_x0_inp2", inp2, 32'd2);

    // Load-use bubble on rs2.
    clr_fwd();
    out_ready = 1'b1;
    issue(5'd1, 32'd3, 5'd4, 32'd0, 32'd0, 1'b0, ALU_ADD, 5'd7);
    tick();
    no_issue();
    ex_fwd_we = 1'b1; ex_fwd_rd = 5'd4; ex_fwd_is_load = 1'b1; ex_fwd_data = 32'hFFFF;
    settle();
    check("lu_bubble_valid", {31'b0, out_valid}, 32'd0);
    check("lu_bubble_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    clr_fwd();
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'h1234;
    issue(5'd1, 32'd3, 5'd4, 32'd0, 32'h10, 1'b1, ALU_ADD, 5'd7);
    settle();
    check("lu_resolved_valid", {31'b0, out_valid}, 32'd1);
    check("lu_resolved_inp2", inp2, 32'h1234);
    // Same load with rs2 unused: no bubble.
    tick();
    no_issue();
    clr_fwd();
    ex_fwd_we = 1'b1; ex_fwd_rd = 5'd4; ex_fwd_is_load = 1'b1;
    settle();
    check("lu_imm_valid", {31'b0, out_valid}, 32'd1);
    check("lu_imm_inp2", inp2, 32'h10);
    check("lu_imm_in_ready", {31'b0, in_ready}, 32'd1);

    // Five-cycle stall with a writeback to x6 in the second cycle.
    clr_fwd();
    issue(5'd6, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, ALU_OR, 5'd8);
    tick();
    no_issue();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        wb_fwd_we = 1'b1; wb_fwd_rd = 5'd6; wb_fwd_data = 32'h55;
      end else begin
        clr_fwd();
      end
      settle();
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      if (c >= 1) check("stall_inp1", inp1, 32'h55);
      tick();
    end

    // Flush kills the held entry and the incoming one.
    clr_fwd();
    issue(5'd10, 32'h77, 5'd0, 32'd0, 32'd0, 1'b0, ALU_XOR, 5'd11);
    flush = 1'b1;
    settle();
    check("flush_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    no_issue();
    settle();
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    tick();
    settle();
    check("flush_no_capture", {31'b0, out_valid}, 32'd0);

    // Reset during a stall.
    issue(5'd11, 32'h33, 5'd12, 32'h44, 32'd0, 1'b0, ALU_XOR, 5'd13);
    tick();
    no_issue();
    settle();
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    check("pre_rst_inp1", inp1, 32'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_inp1", inp1, 32'd0);
    check("mid_rst_inp2", inp2, 32'd0);
    check("mid_rst_ctrl", {28'b0, alu_control}, 32'd0);

    // Capture bypass of a same-cycle writeback.
    out_ready = 1'b1;
    issue(5'd7, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, ALU_ADD, 5'd1);
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'h99;
    tick();
    no_issue();
    clr_fwd();
    settle();
    check("bypass_valid", {31'b0, out_valid}, 32'd1);
    check("bypass_inp1", inp1, 32'h99);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
